usd_apu_bridge: RTL and testbench

- APU-side front end of the micro-SD controller, in the apuClk domain.
- Packs 32-bit APU store words into 72-bit words for the command FIFO and write-data FIFO, honouring their almost-full flags.
- Pops the 36-bit result FIFO and the 72-bit read-data FIFO, returning 32-bit words plus status to the APU.
- Directly upstream of the SD command/data FIFOs and downstream of their result side.

---
 rtl/usd_bridge_pkg.sv | 39 +++
 rtl/usd_apu_bridge_if.sv | 36 +++
 rtl/usd_word_packer.sv | 152 +++++++++++++++
 rtl/usd_apu_bridge.sv | 177 +++++++++++++++++
 tb/tb_usd_apu_bridge.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usd_bridge_pkg.sv
// ---------------------------------------------------------------------------
// usd_bridge_pkg
// Shared definitions for the APU-side micro-SD bridge:
//   - write/read FSM state encodings
//   - default values for the sync tag and the empty-FIFO read status
//   - bit offsets of the fields inside the 72-bit FIFO word and the
//     36-bit result word
// ---------------------------------------------------------------------------
package usd_bridge_pkg;

    // Write side: nothing held, or the low half of a pair is held.
    typedef enum logic {
        W_EMPTY = 1'b0,
        W_HALF  = 1'b1
    } wrState_t;

    // Read side: idle, popping, capturing FIFO dout, holding an upper half.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_POP  = 2'd1,
        R_CAP  = 2'd2,
        R_HI   = 2'd3
    } rdState_t;

    localparam logic [3:0] SYNC_TAG_DEFAULT     = 4'hA;
    localparam logic [3:0] EMPTY_STATUS_DEFAULT = 4'hF;

    // 72-bit FIFO word layout: {tag[71:64], hi[63:32], lo[31:0]}
    localparam int WORD_LO_LSB = 0;
    localparam int WORD_HI_LSB = 32;
    localparam int WORD_TAG_LSB = 64;
    localparam int HALF_WIDTH  = 32;
    localparam int TAG_WIDTH   = 8;

    // 36-bit result word layout: {status[35:32], data[31:0]}
    localparam int RESULT_STATUS_LSB = 32;
    localparam int STATUS_WIDTH      = 4;

endpackage

// File: rtl/usd_apu_bridge_if.sv
// ---------------------------------------------------------------------------
// usd_apu_bridge_if
// APU load/store bus seen by the micro-SD bridge.
//   Store side : wrValid, wrSel, wrLast, wrData (APU -> bridge), wrRdy (back)
//   Load side  : rdReq, rdSel (APU -> bridge),
//                rdBusy, rdValid, rdData, rdStatus (bridge -> APU)
// Modports:
//   master - the APU (drives requests, observes responses)
//   slave  - the bridge
// ---------------------------------------------------------------------------
interface usd_apu_bridge_if;

    logic        wrValid;
    logic        wrRdy;
    logic        wrSel;
    logic        wrLast;
    logic [31:0] wrData;

    logic        rdReq;
    logic        rdSel;
    logic        rdBusy;
    logic        rdValid;
    logic [31:0] rdData;
    logic [3:0]  rdStatus;

    modport master (
        output wrValid, wrSel, wrLast, wrData, rdReq, rdSel,
        input  wrRdy, rdBusy, rdValid, rdData, rdStatus
    );

    modport slave (
        input  wrValid, wrSel, wrLast, wrData, rdReq, rdSel,
        output wrRdy, rdBusy, rdValid, rdData, rdStatus
    );

endinterface

// File: rtl/usd_word_packer.sv
// ---------------------------------------------------------------------------
// usd_word_packer
// Write FSM of the bridge: packs 32-bit APU store words into 72-bit words
// {tag, hi, lo} and emits them to the command FIFO (sel=0) or the
// write-data FIFO (sel=1), one registered strobe per word.
//
// Ports:
//   apuClk, sysRst        clock, asynchronous active-high reset
//   wrValid/wrRdy         store handshake (accept = wrValid & wrRdy)
//   wrSel, wrLast, wrData store target, single-word flag, store word
//   cmdFifoAfull          command FIFO almost full
//   dataFifoAfull         write-data FIFO almost full
//   cmdFifoData/WrEn      packed command word and write strobe
//   cmdDataFifoData/WrEn  packed write-data word and write strobe
//
// Build option USD_BRIDGE_PARITY_EN: when defined the tag is the per-byte
// even parity of the 64 data bits (bit 64 covers byte 0) and the sequence
// counter is removed; otherwise the tag is {SYNC_TAG, seq}.
// ---------------------------------------------------------------------------
module usd_word_packer
    import usd_bridge_pkg::*;
#(
    parameter logic [3:0] SYNC_TAG = SYNC_TAG_DEFAULT
) (
    input  logic        apuClk,
    input  logic        sysRst,
    input  logic        wrValid,
    output logic        wrRdy,
    input  logic        wrSel,
    input  logic        wrLast,
    input  logic [31:0] wrData,
    input  logic        cmdFifoAfull,
    input  logic        dataFifoAfull,
    output logic [71:0] cmdFifoData,
    output logic        cmdFifoWrEn,
    output logic [71:0] cmdDataFifoData,
    output logic        cmdDataFifoWrEn
);

    wrState_t    state;
    wrState_t    stateNext;
    logic        selQ;
    logic [31:0] lowWord;

    logic        targetAfull;
    logic        accept;
    logic        emitEn;
    logic        emitSel;
    logic [63:0] emitPayload;
    logic [7:0]  emitTag;

`ifndef USD_BRIDGE_PARITY_EN
    logic [3:0]  seq;
`endif

    // Flow control follows the FIFO the current word is headed for: the live
    // wrSel when starting a word, the stored selection once a half is held.
    always_comb begin
        targetAfull = 1'b0;
        if (state == W_EMPTY) begin
            targetAfull = wrSel ? dataFifoAfull : cmdFifoAfull;
        end else begin
            targetAfull = selQ ? dataFifoAfull : cmdFifoAfull;
        end
    end

    // Held low while in reset so nothing is accepted until the FSM is clean.
    assign wrRdy  = ~sysRst & ~targetAfull;
    assign accept = wrValid & wrRdy;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        stateNext   = state;
        emitEn      = 1'b0;
        emitSel     = selQ;
        emitPayload = {wrData, lowWord};
        unique case (state)
            W_EMPTY: begin
                if (accept) begin
                    if (wrLast) begin
                        emitEn      = 1'b1;
                        emitSel     = wrSel;
                        emitPayload = {32'h0, wrData};
                    end else begin
                        stateNext = W_HALF;
                    end
                end
            end
            W_HALF: begin
                // wrSel/wrLast are ignored here; the pair completes on the
                // channel chosen by its first word.
                if (accept) begin
                    emitEn    = 1'b1;
                    stateNext = W_EMPTY;
                end
            end
            default: stateNext = W_EMPTY;
        endcase
    end

    always_comb begin
        emitTag = '0;
`ifdef USD_BRIDGE_PARITY_EN
        for (int i = 0; i < TAG_WIDTH; i++) begin
            emitTag[i] = ^emitPayload[8*i +: 8];
        end
`else
        emitTag = {SYNC_TAG, seq};
`endif
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    // NOTE: the held half-word and selection are reset too, so a reset in
    // the middle of a pair can never leak stale data into a later word.
    always_ff @(posedge apuClk or posedge sysRst) begin
        if (sysRst) begin
            state           <= W_EMPTY;
            selQ            <= 1'b0;
            lowWord         <= '0;
            cmdFifoData     <= '0;
            cmdFifoWrEn     <= 1'b0;
            cmdDataFifoData <= '0;
            cmdDataFifoWrEn <= 1'b0;
`ifndef USD_BRIDGE_PARITY_EN
            seq             <= '0;
`endif
        end else begin
            state           <= stateNext;
            cmdFifoWrEn     <= emitEn & ~emitSel;
            cmdDataFifoWrEn <= emitEn & emitSel;

            if ((state == W_EMPTY) && accept && !wrLast) begin
                lowWord <= wrData;
                selQ    <= wrSel;
            end

            if (emitEn) begin
                if (emitSel) begin
                    cmdDataFifoData <= {emitTag, emitPayload};
                end else begin
                    cmdFifoData <= {emitTag, emitPayload};
                end
`ifndef USD_BRIDGE_PARITY_EN
                seq <= seq + 4'd1;
`endif
            end
        end
    end

endmodule

// File: rtl/usd_apu_bridge.sv
// ---------------------------------------------------------------------------
// usd_apu_bridge
// APU-side front end of the micro-SD controller (apuClk domain).
// Store path: usd_word_packer packs 32-bit stores into 72-bit words for the
// command FIFO and the write-data FIFO.
// Load path: a read FSM pops the 36-bit result FIFO or the 72-bit read-data
// FIFO and returns 32-bit words with a 4-bit status. A read-data word is
// returned in two loads: the low half after the pop, the upper half from a
// holding register on the next rdSel=1 load.
//
// Ports:
//   apuClk, sysRst           clock, asynchronous active-high reset
//   apu (slave modport)      APU store/load bus
//   cmdFifoData/WrEn/Afull   command FIFO write side
//   cmdDataFifoData/WrEn     write-data FIFO write side
//   dataFifoAfull            write-data FIFO almost full
//   resultFifoData/RdEn      result FIFO dout and pop
//   resultPending            result FIFO not empty
//   resultDataFifoData/RdEn  read-data FIFO dout and pop
//   resultDataEmpty          read-data FIFO empty
//
// Build option USD_BRIDGE_PARITY_EN selects parity tags in the packed words
// (see usd_word_packer).
// ---------------------------------------------------------------------------
module usd_apu_bridge
    import usd_bridge_pkg::*;
#(
    parameter logic [3:0] SYNC_TAG     = SYNC_TAG_DEFAULT,
    parameter logic [3:0] EMPTY_STATUS = EMPTY_STATUS_DEFAULT
) (
    input  logic                 apuClk,
    input  logic                 sysRst,
    usd_apu_bridge_if.slave      apu,
    output logic [71:0]          cmdFifoData,
    output logic                 cmdFifoWrEn,
    input  logic                 cmdFifoAfull,
    output logic [71:0]          cmdDataFifoData,
    output logic                 cmdDataFifoWrEn,
    input  logic                 dataFifoAfull,
    input  logic [35:0]          resultFifoData,
    output logic                 resultFifoRdEn,
    input  logic                 resultPending,
    input  logic [71:0]          resultDataFifoData,
    output logic                 resultDataFifoRdEn,
    input  logic                 resultDataEmpty
);

    // ---------------- write side ----------------
    usd_word_packer #(
        .SYNC_TAG (SYNC_TAG)
    ) uPacker (
        .apuClk          (apuClk),
        .sysRst          (sysRst),
        .wrValid         (apu.wrValid),
        .wrRdy           (apu.wrRdy),
        .wrSel           (apu.wrSel),
        .wrLast          (apu.wrLast),
        .wrData          (apu.wrData),
        .cmdFifoAfull    (cmdFifoAfull),
        .dataFifoAfull   (dataFifoAfull),
        .cmdFifoData     (cmdFifoData),
        .cmdFifoWrEn     (cmdFifoWrEn),
        .cmdDataFifoData (cmdDataFifoData),
        .cmdDataFifoWrEn (cmdDataFifoWrEn)
    );

    // ---------------- read side ----------------
    rdState_t    rdState;
    rdState_t    rdStateNext;
    logic        reqSel;
    logic [31:0] hiWord;
    logic        hiValid;

    logic        selEmpty;
    logic        startPop;
    logic        respondEmpty;
    logic        respondHi;

    logic        rdValidQ;
    logic [31:0] rdDataQ;
    logic [3:0]  rdStatusQ;

    // The read-data tag byte is not returned to the APU.
    logic        unusedTag;
    assign unusedTag = ^resultDataFifoData[WORD_TAG_LSB +: TAG_WIDTH];

    // The held upper half is represented by R_HI, so the busy flag covers it.
    assign hiValid     = (rdState == R_HI);
    assign apu.rdBusy  = (rdState != R_IDLE) || hiValid;
    assign selEmpty    = apu.rdSel ? resultDataEmpty : ~resultPending;

    always_comb begin
        rdStateNext        = rdState;
        resultFifoRdEn     = 1'b0;
        resultDataFifoRdEn = 1'b0;
        startPop           = 1'b0;
        respondEmpty       = 1'b0;
        respondHi          = 1'b0;
        unique case (rdState)
            R_IDLE: begin
                if (apu.rdReq) begin
                    if (selEmpty) begin
                        respondEmpty = 1'b1;
                    end else begin
                        startPop    = 1'b1;
                        rdStateNext = R_POP;
                    end
                end
            end
            R_POP: begin
                // Single-cycle pop; dout is valid one cycle later in R_CAP.
                resultFifoRdEn     = ~reqSel;
                resultDataFifoRdEn = reqSel;
                rdStateNext        = R_CAP;
            end
            R_CAP: begin
                rdStateNext = reqSel ? R_HI : R_IDLE;
            end
            R_HI: begin
                // Only a read-data load can drain the held half; result
                // loads are dropped until it has been returned.
                if (apu.rdReq && apu.rdSel) begin
                    respondHi   = 1'b1;
                    rdStateNext = R_IDLE;
                end
            end
            default: rdStateNext = R_IDLE;
        endcase
    end

    always_ff @(posedge apuClk or posedge sysRst) begin
        if (sysRst) begin
            rdState   <= R_IDLE;
            reqSel    <= 1'b0;
            hiWord    <= '0;
            rdValidQ  <= 1'b0;
            rdDataQ   <= '0;
            rdStatusQ <= '0;
        end else begin
            rdState  <= rdStateNext;
            rdValidQ <= 1'b0;

            if (startPop) begin
                reqSel <= apu.rdSel;
            end

            if (respondEmpty) begin
                rdValidQ  <= 1'b1;
                rdDataQ   <= '0;
                rdStatusQ <= EMPTY_STATUS;
            end

            if (rdState == R_CAP) begin
                rdValidQ <= 1'b1;
                if (reqSel) begin
                    rdDataQ   <= resultDataFifoData[WORD_LO_LSB +: HALF_WIDTH];
                    hiWord    <= resultDataFifoData[WORD_HI_LSB +: HALF_WIDTH];
                    rdStatusQ <= '0;
                end else begin
                    rdDataQ   <= resultFifoData[WORD_LO_LSB +: HALF_WIDTH];
                    rdStatusQ <= resultFifoData[RESULT_STATUS_LSB +: STATUS_WIDTH];
                end
            end

            if (respondHi) begin
                rdValidQ  <= 1'b1;
                rdDataQ   <= hiWord;
                rdStatusQ <= '0;
            end
        end
    end

    assign apu.rdValid  = rdValidQ;
    assign apu.rdData   = rdDataQ;
    assign apu.rdStatus = rdStatusQ;

endmodule

// File: tb/tb_usd_apu_bridge.sv
// ---------------------------------------------------------------------------
// tb_usd_apu_bridge
// Self-checking bench for usd_apu_bridge (default build: {SYNC_TAG, seq}
// tags). Inputs change 1 ns after a rising edge; outputs are compared
// 1-2 ns after the edge, never on it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usd_apu_bridge;

    logic        apuClk = 1'b0;
    logic        sysRst;
    logic [71:0] cmdFifoData;
    logic        cmdFifoWrEn;
    logic        cmdFifoAfull;
    logic [71:0] cmdDataFifoData;
    logic        cmdDataFifoWrEn;
    logic        dataFifoAfull;
    logic [35:0] resultFifoData;
    logic        resultFifoRdEn;
    logic        resultPending;
    logic [71:0] resultDataFifoData;
    logic        resultDataFifoRdEn;
    logic        resultDataEmpty;

    usd_apu_bridge_if apu ();

    usd_apu_bridge dut (
        .apuClk             (apuClk),
        .sysRst             (sysRst),
        .apu                (apu),
        .cmdFifoData        (cmdFifoData),
        .cmdFifoWrEn        (cmdFifoWrEn),
        .cmdFifoAfull       (cmdFifoAfull),
        .cmdDataFifoData    (cmdDataFifoData),
        .cmdDataFifoWrEn    (cmdDataFifoWrEn),
        .dataFifoAfull      (dataFifoAfull),
        .resultFifoData     (resultFifoData),
        .resultFifoRdEn     (resultFifoRdEn),
        .resultPending      (resultPending),
        .resultDataFifoData (resultDataFifoData),
        .resultDataFifoRdEn (resultDataFifoRdEn),
        .resultDataEmpty    (resultDataEmpty)
    );

    always #5 apuClk = ~apuClk;

    int nCompared = 0;
    int nMismatched = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge apuClk);
        #1;
    endtask

    typedef struct {
        logic        sel;
        logic        last;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [71:0] expWord;
    } wrVec_t;

    wrVec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h11111111, 32'h22222222, 72'hA0_22222222_11111111};
        vecs[1] = '{1'b0, 1'b0, 32'h33333333, 32'h44444444, 72'hA1_44444444_33333333};
        vecs[2] = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h0,        72'hA2_00000000_DEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h01234567, 32'h89ABCDEF, 72'hA3_89ABCDEF_01234567};
        vecs[4] = '{1'b0, 1'b1, 32'h0000FFFF, 32'h0,        72'hA4_00000000_0000FFFF};

        sysRst             = 1'b1;
        apu.wrValid        = 1'b0;
        apu.wrSel          = 1'b0;
        apu.wrLast         = 1'b0;
        apu.wrData         = '0;
        apu.rdReq          = 1'b0;
        apu.rdSel          = 1'b0;
        cmdFifoAfull       = 1'b0;
        dataFifoAfull      = 1'b0;
        resultFifoData     = '0;
        resultPending      = 1'b0;
        resultDataFifoData = '0;
        resultDataEmpty    = 1'b1;

        // ---- reset state ----
        repeat (2) cyc();
        check("rst_cmdWrEn",  cmdFifoWrEn, 0);
        check("rst_dataWrEn", cmdDataFifoWrEn, 0);
        check("rst_cmdData",  cmdFifoData, 0);
        check("rst_rdValid",  apu.rdValid, 0);
        check("rst_rdBusy",   apu.rdBusy, 0);
        check("rst_rdData",   apu.rdData, 0);
        check("rst_rdStatus", apu.rdStatus, 0);
        check("rst_wrRdy",    apu.wrRdy, 0);
        sysRst = 1'b0;
        cyc();

        // ---- table-driven store vectors ----
        for (int i = 0; i < 5; i++) begin
            apu.wrValid = 1'b1;
            apu.wrSel   = vecs[i].sel;
            apu.wrLast  = vecs[i].last;
            apu.wrData  = vecs[i].lo;
            #1 check($sformatf("v%0d_wrRdy", i), apu.wrRdy, 1);
            cyc();
            if (!vecs[i].last) begin
                check($sformatf("v%0d_noEarlyEmit", i), {cmdFifoWrEn, cmdDataFifoWrEn}, 2'b00);
                apu.wrSel  = ~vecs[i].sel;   // ignored in W_HALF
                apu.wrLast = 1'b1;           // ignored in W_HALF
                apu.wrData = vecs[i].hi;
                cyc();
            end
            apu.wrValid = 1'b0;
            check($sformatf("v%0d_cmdWrEn", i), cmdFifoWrEn, !vecs[i].sel);
            check($sformatf("v%0d_dataWrEn", i), cmdDataFifoWrEn, vecs[i].sel);
            check($sformatf("v%0d_word", i),
                  vecs[i].sel ? cmdDataFifoData : cmdFifoData, vecs[i].expWord);
            cyc();
            check($sformatf("v%0d_strobeDrop", i), {cmdFifoWrEn, cmdDataFifoWrEn}, 2'b00);
        end

        // ---- seq counts 5..15 then wraps to 0 ----
        for (int k = 5; k <= 16; k++) begin
            logic [31:0] w;
            logic [3:0]  s;
            w = 32'h1000_0000 + k;
            s = k[3:0];
            apu.wrValid = 1'b1;
            apu.wrSel   = 1'b0;
            apu.wrLast  = 1'b1;
            apu.wrData  = w;
            cyc();
            apu.wrValid = 1'b0;
            check($sformatf("seq%0d_word", k), cmdFifoData, {4'hA, s, 32'h0, w});
        end
        cyc();

        // ---- afull while half held: hold, then complete intact (seq=1) ----
        apu.wrValid = 1'b1;
        apu.wrSel   = 1'b1;
        apu.wrLast  = 1'b0;
        apu.wrData  = 32'hAAAA0001;
        cyc();
        dataFifoAfull = 1'b1;
        apu.wrSel     = 1'b0;        // stored sel must still govern wrRdy
        apu.wrData    = 32'hBBBB0002;
        for (int c = 0; c < 5; c++) begin
            #1 check($sformatf("afull_wrRdy%0d", c), apu.wrRdy, 0);
            check($sformatf("afull_noWr%0d", c), cmdDataFifoWrEn, 0);
            cyc();
        end
        dataFifoAfull = 1'b0;
        #1 check("afull_release_wrRdy", apu.wrRdy, 1);
        cyc();
        apu.wrValid = 1'b0;
        check("afull_dataWrEn", cmdDataFifoWrEn, 1);
        check("afull_word", cmdDataFifoData, 72'hA1_BBBB0002_AAAA0001);
        check("afull_cmdWrEn", cmdFifoWrEn, 0);
        cyc();

        // ---- reset in W_HALF: no write, half discarded, seq back to 0 ----
        apu.wrValid = 1'b1;
        apu.wrSel   = 1'b0;
        apu.wrLast  = 1'b0;
        apu.wrData  = 32'hCCCC0003;
        cyc();
        apu.wrValid = 1'b0;
        sysRst = 1'b1;
        #1 check("midrst_cmdWrEn", cmdFifoWrEn, 0);
        check("midrst_wrRdy", apu.wrRdy, 0);
        cyc();
        sysRst = 1'b0;
        cyc();
        check("postrst_noWr", cmdFifoWrEn, 0);
        apu.wrValid = 1'b1;
        apu.wrLast  = 1'b1;
        apu.wrData  = 32'h55555555;
        cyc();
        apu.wrValid = 1'b0;
        check("postrst_cmdWrEn", cmdFifoWrEn, 1);
        check("postrst_word", cmdFifoData, 72'hA0_00000000_55555555);
        cyc();

        // ---- result FIFO read: one pop, rdValid at +3 ----
        resultFifoData = 36'h5_CAFEF00D;
        resultPending  = 1'b1;
        apu.rdReq = 1'b1;
        apu.rdSel = 1'b0;
        #1 check("res_c0_rdEn", resultFifoRdEn, 0);
        cyc();
        apu.rdReq = 1'b0;
        check("res_c1_rdEn", resultFifoRdEn, 1);
        check("res_c1_busy", apu.rdBusy, 1);
        check("res_c1_valid", apu.rdValid, 0);
        cyc();
        check("res_c2_rdEn", resultFifoRdEn, 0);
        check("res_c2_valid", apu.rdValid, 0);
        cyc();
        check("res_c3_valid", apu.rdValid, 1);
        check("res_c3_data", apu.rdData, 32'hCAFEF00D);
        check("res_c3_status", apu.rdStatus, 4'h5);
        check("res_c3_rdEn", resultFifoRdEn, 0);
        cyc();
        check("res_c4_valid", apu.rdValid, 0);

        // ---- read-data FIFO: low at +3, upper at +1 without a second pop ----
        resultDataFifoData = 72'h5C_89ABCDEF_01234567;
        resultDataEmpty    = 1'b0;
        apu.rdReq = 1'b1;
        apu.rdSel = 1'b1;
        cyc();
        apu.rdReq = 1'b0;
        check("rd_c1_rdEn", resultDataFifoRdEn, 1);
        cyc();
        check("rd_c2_rdEn", resultDataFifoRdEn, 0);
        cyc();
        check("rd_c3_valid", apu.rdValid, 1);
        check("rd_c3_data", apu.rdData, 32'h01234567);
        check("rd_c3_status", apu.rdStatus, 4'h0);
        check("rd_c3_busy", apu.rdBusy, 1);
        apu.rdReq = 1'b1;
        apu.rdSel = 1'b0;
        #1 check("rd_ignRes_rdEn", resultFifoRdEn, 0);
        cyc();
        apu.rdReq = 1'b0;
        check("rd_ignRes_valid", apu.rdValid, 0);
        check("rd_ignRes_busy", apu.rdBusy, 1);
        check("rd_ignRes_rdEn2", resultFifoRdEn, 0);
        apu.rdReq = 1'b1;
        apu.rdSel = 1'b1;
        #1 check("rd_hi_noPop", resultDataFifoRdEn, 0);
        cyc();
        apu.rdReq = 1'b0;
        check("rd_hi_valid", apu.rdValid, 1);
        check("rd_hi_data", apu.rdData, 32'h89ABCDEF);
        check("rd_hi_status", apu.rdStatus, 4'h0);
        check("rd_hi_busy", apu.rdBusy, 0);
        check("rd_hi_noPop2", resultDataFifoRdEn, 0);
        cyc();

        // ---- empty result FIFO, concurrent store on the write side ----
        resultPending = 1'b0;
        apu.rdReq   = 1'b1;
        apu.rdSel   = 1'b0;
        apu.wrValid = 1'b1;
        apu.wrSel   = 1'b1;
        apu.wrLast  = 1'b1;
        apu.wrData  = 32'h77777777;
        #1 check("empty_noPop", resultFifoRdEn, 0);
        cyc();
        apu.rdReq   = 1'b0;
        apu.wrValid = 1'b0;
        check("empty_valid", apu.rdValid, 1);
        check("empty_data", apu.rdData, 32'h0);
        check("empty_status", apu.rdStatus, 4'hF);
        check("empty_busy", apu.rdBusy, 0);
        check("concurrent_dataWrEn", cmdDataFifoWrEn, 1);
        check("concurrent_word", cmdDataFifoData, 72'hA1_00000000_77777777);

        // ---- empty read-data FIFO ----
        resultDataEmpty = 1'b1;
        apu.rdReq = 1'b1;
        apu.rdSel = 1'b1;
        #1 check("emptyRd_noPop", resultDataFifoRdEn, 0);
        cyc();
        apu.rdReq = 1'b0;
        check("emptyRd_valid", apu.rdValid, 1);
        check("emptyRd_status", apu.rdStatus, 4'hF);
        cyc();
        check("emptyRd_validDrop", apu.rdValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
